// File: rtl/cpu_pkg.sv
// Constants and the fetch-queue entry layout shared by the CPU front end.
package cpu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Front-end bundle: redirect from next-PC, instruction memory port, decode port.
interface fetch_unit_if import cpu_pkg::*;;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_gnt;
    logic            im_rvalid;
    logic [XLEN-1:0] im_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, inst_ready,
        output im_req, im_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, inst_ready,
        input  im_req, im_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/inst_queue.sv
// Instruction queue: DEPTH-entry ring of {pc, inst}, flush clears all entries.
// Latency: pushed entry visible at head the next cycle; no write-through bypass.
// Backpressure: push dropped only when full without a same-cycle pop; flush wins.
module inst_queue import cpu_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    output fetch_entry_t                 head_dat,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (do_push && reset && !flush) mem_q[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word fetch with redirect, response drop and credit-limited queue.
// Latency: redirect -> im_req at target next cycle; response -> inst_valid next cycle.
// Backpressure: im_req only while outstanding + queued < QDEPTH, so responses always fit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    import cpu_pkg::XLEN;
    import cpu_pkg::PC_INC;
    import cpu_pkg::fetch_entry_t;
    import cpu_pkg::word_align;

    localparam int            CW   = $clog2(QDEPTH+1);
    localparam logic [CW:0]   QLIM = (CW+1)'(QDEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic            live_q;
    logic            grant;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            q_empty;
    logic [XLEN-1:0] target;
    fetch_entry_t    push_dat;
    fetch_entry_t    head_dat;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign rsp    = bus.im_rvalid && (outstanding != '0);
    assign target = word_align(bus.redirect_pc);

    // live_q holds im_req low for the first cycle after reset.
    assign bus.im_req  = reset && live_q && !bus.redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, q_count}) < QLIM);
    assign bus.im_addr = pc_q;
    assign grant       = bus.im_req && bus.im_gnt;

    assign push     = rsp && (drop_cnt == '0) && !bus.redirect_valid;
    assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign push_dat = '{pc: resp_pc, inst: bus.im_rdata};

    assign bus.inst_valid = reset && !q_empty;
    assign bus.inst       = head_dat.inst;
    assign bus.inst_pc    = head_dat.pc;

    inst_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.redirect_valid),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            live_q      <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (bus.redirect_valid) begin
                pc_q     <= target;
                resp_pc  <= target;
                // Everything still in flight belongs to the old path.
                drop_cnt <= outstanding - CW'(rsp);
            end else begin
                if (grant) pc_q    <= pc_q + PC_INC;
                if (push)  resp_pc <= resp_pc + PC_INC;
                if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset) bus.im_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against an epoch-tagged memory/queue model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          QD  = 3;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; }    ent_t;

    // Model: memory requests in flight (tagged with the path epoch) and the decode queue.
    pend_t       pend[$];
    ent_t        q[$];
    logic [31:0] exp_pc = RPC;
    int          epoch  = 0;
    bit          live   = 0;
    int          cyc    = 0;

    int errors = 0;
    int checks = 0;

    logic        drv_reset    = 1'b0;
    logic        drv_redirect = 1'b0;
    logic [31:0] drv_target   = '0;
    logic        drv_gnt      = 1'b0;
    logic        drv_ready    = 1'b0;
    int          lat_lo       = 1;
    int          lat_hi       = 1;

    logic        s_req, s_vld;
    logic [31:0] s_addr, s_pc, s_inst;
    bit          s_grant;
    int          s_drop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model at posedge.
    task automatic step();
        bit    rsp_now;
        bit    exp_req;
        bit    keep;
        pend_t pe;
        pend_t pn;
        ent_t  en;
        @(negedge clk);
        reset              = drv_reset;
        rsp_now            = drv_reset && pend.size() > 0 && pend[0].due <= cyc;
        bus.redirect_valid = drv_reset && drv_redirect;
        bus.redirect_pc    = drv_target;
        bus.im_gnt         = drv_gnt;
        bus.inst_ready     = drv_ready;
        bus.im_rvalid      = rsp_now;
        bus.im_rdata       = rsp_now ? mem_word(pend[0].addr) : $urandom;
        #1;
        exp_req = drv_reset && live && !drv_redirect && (pend.size() + q.size() < QD);
        s_req  = bus.im_req;
        s_addr = bus.im_addr;
        s_vld  = bus.inst_valid;
        s_pc   = bus.inst_pc;
        s_inst = bus.inst;
        s_drop = int'(dut.drop_cnt);
        check("im_req", {31'b0, s_req}, {31'b0, exp_req});
        if (drv_reset) check("im_addr", s_addr, exp_pc);
        check("inst_valid", {31'b0, s_vld}, {31'b0, (drv_reset && q.size() > 0)});
        if (drv_reset && q.size() > 0) begin
            check("inst_pc", s_pc, q[0].pc);
            check("inst", s_inst, q[0].inst);
        end
        s_grant = exp_req && drv_gnt;
        @(posedge clk);
        if (!drv_reset) begin
            pend.delete();
            q.delete();
            exp_pc = RPC;
            live   = 0;
            epoch++;
        end else begin
            live = 1;
            keep = 0;
            if (rsp_now) begin
                pe   = pend.pop_front();
                keep = !drv_redirect && pe.epoch == epoch;
            end
            if (q.size() > 0 && drv_ready && !drv_redirect) void'(q.pop_front());
            if (keep) begin
                en.pc   = pe.addr;
                en.inst = mem_word(pe.addr);
                q.push_back(en);
            end
            if (s_grant) begin
                pn.addr  = exp_pc;
                pn.epoch = epoch;
                pn.due   = cyc + $urandom_range(lat_hi, lat_lo);
                pend.push_back(pn);
                exp_pc += 32'd4;
            end
            if (drv_redirect) begin
                q.delete();
                epoch++;
                exp_pc = {drv_target[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_reset    = 1'b0;
        drv_redirect = 1'b0;
        drv_gnt      = 1'b0;
        drv_ready    = 1'b0;
        step();
        step();
        check("rst_req", {31'b0, s_req}, 32'd0);
        check("rst_vld", {31'b0, s_vld}, 32'd0);
        drv_reset = 1'b1;
    endtask

    initial begin
        int n;
        int g_cnt;
        int g_cyc;
        int v_cyc;
        logic [31:0] a0;
        logic [31:0] ga[$];
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.im_gnt         = 1'b0;
        bus.im_rvalid      = 1'b0;
        bus.im_rdata       = '0;
        bus.inst_ready     = 1'b0;

        // Reset release, streaming with 1-cycle memory.
        do_reset();
        drv_gnt = 1; drv_ready = 1; lat_lo = 1; lat_hi = 1;
        step();
        check("post_rst_req", {31'b0, s_req}, 32'd0);
        check("post_rst_vld", {31'b0, s_vld}, 32'd0);
        g_cyc = -1; v_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_grant) begin
                ga.push_back(s_addr);
                if (g_cyc < 0) g_cyc = cyc - 1;
            end
            if (s_vld && v_cyc < 0) begin
                v_cyc = cyc - 1;
                check("first_inst_pc", s_pc, 32'h0000_3000);
            end
        end
        check("stream_grants", {31'b0, (ga.size() >= 2)}, 32'd1);
        if (ga.size() >= 2) begin
            check("grant0_addr", ga[0], 32'h0000_3000);
            check("grant1_addr", ga[1], 32'h0000_3004);
        end
        check("vld_after_grant", {31'b0, (g_cyc >= 0 && v_cyc - g_cyc >= 2)}, 32'd1);

        // Decode stalled: exactly QD grants, then resume sequentially.
        do_reset();
        drv_gnt = 1; drv_ready = 0; lat_lo = 1; lat_hi = 2;
        g_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (s_grant) g_cnt++;
        end
        check("stall_grants", g_cnt, QD);
        check("stall_req", {31'b0, s_req}, 32'd0);
        drv_ready = 1;
        n = 0;
        do begin step(); n++; end while (!s_grant && n < 10);
        check("resume_seen", {31'b0, s_grant}, 32'd1);
        check("resume_addr", s_addr, 32'h0000_300C);

        // Redirect to 0x3400 with two requests outstanding.
        do_reset();
        drv_gnt = 1; drv_ready = 1; lat_lo = 6; lat_hi = 6;
        n = 0;
        while (pend.size() < 2 && n < 10) begin step(); n++; end
        drv_gnt = 0;
        check("two_outstanding", pend.size(), 2);
        drv_redirect = 1; drv_target = 32'h0000_3400;
        step();
        drv_redirect = 0; drv_gnt = 1;
        step();
        check("redir_addr", s_addr, 32'h0000_3400);
        check("redir_req", {31'b0, s_req}, 32'd1);
        n = 0;
        do begin step(); n++; end while (!s_vld && n < 30);
        check("redir_first_pc", s_pc, 32'h0000_3400);

        // Unaligned redirect coinciding with pop and a response.
        do_reset();
        drv_gnt = 1; drv_ready = 0; lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!(pend.size() == 2 && pend[0].due <= cyc && q.size() > 0) && n < 20) begin step(); n++; end
        check("coincide_setup", {31'b0, (n < 20)}, 32'd1);
        drv_redirect = 1; drv_target = 32'h0000_3403; drv_ready = 1;
        step();
        check("coincide_vld_before", {31'b0, s_vld}, 32'd1);
        drv_redirect = 0; drv_ready = 0; drv_gnt = 0;
        step();
        check("coincide_vld", {31'b0, s_vld}, 32'd0);
        check("coincide_addr", s_addr, 32'h0000_3400);
        check("coincide_drop", s_drop, 1);

        // Grant withheld for three cycles.
        do_reset();
        drv_gnt = 0; drv_ready = 1; lat_lo = 1; lat_hi = 1;
        step();
        step();
        a0 = s_addr;
        check("hold_addr0", a0, 32'h0000_3000);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_addr", s_addr, 32'h0000_3000);
            check("hold_vld", {31'b0, s_vld}, 32'd0);
        end
        drv_gnt = 1;
        step();
        step();
        check("hold_next_addr", s_addr, 32'h0000_3004);

        // Reset mid-stream with a full queue.
        do_reset();
        drv_gnt = 1; drv_ready = 0; lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 15; i++) step();
        check("full_vld", {31'b0, s_vld}, 32'd1);
        drv_reset = 0;
        step();
        drv_reset = 1; drv_ready = 1;
        step();
        check("midrst_vld", {31'b0, s_vld}, 32'd0);
        check("midrst_req", {31'b0, s_req}, 32'd0);
        n = 0;
        do begin step(); n++; end while (!s_grant && n < 10);
        check("midrst_resume", s_addr, 32'h0000_3000);

        // Random traffic.
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 4000; i++) begin
            drv_reset    = ($urandom_range(499, 0) != 0);
            drv_gnt      = ($urandom_range(9, 0) < 7);
            drv_ready    = ($urandom_range(9, 0) < 6);
            drv_redirect = ($urandom_range(24, 0) == 0);
            drv_target   = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
